// File: rtl/disp_bcd_formatter.sv
// Display-word formatter for the four-digit seven-segment driver.
// Each sample is shown either as raw hex or as 4-digit packed BCD (sequential double-dabble).
module disp_bcd_formatter #(
    parameter int SAMPLE_DIV = 100000,
    parameter bit AUTO_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        mode,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] display_data
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    iter_q, iter_d;
    logic [15:0]   display_q, display_d;
    logic          overflow_q, overflow_d;

    logic          tick;
    logic          trigger;
    logic [15:0]   bcd_adj;
    logic [31:0]   shifted;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        tick    = AUTO_EN && (cnt_q == CNT_LAST);
        trigger = start | tick;

        bcd_adj = {dabble(bcd_q[15:12]), dabble(bcd_q[11:8]),
                   dabble(bcd_q[7:4]),   dabble(bcd_q[3:0])};
        shifted = {bcd_adj, bin_q} << 1;

        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        display_d  = display_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                // Operands are captured here; later input changes cannot affect this update.
                if (trigger) begin
                    if (!mode) begin
                        display_d  = value_in;
                        overflow_d = 1'b0;
                        state_d    = S_DONE;
                    end else if (value_in > 16'd9999) begin
                        display_d  = 16'hEEEE;
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        bin_d   = value_in;
                        bcd_d   = '0;
                        iter_d  = '0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                bcd_d  = shifted[31:16];
                bin_d  = shifted[15:0];
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    display_d  = shifted[31:16];
                    overflow_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            display_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            display_q  <= display_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy         = (state_q == S_SHIFT);
    assign done         = (state_q == S_DONE);
    assign overflow     = overflow_q;
    assign display_data = display_q;

endmodule

// File: doc/disp_bcd_formatter.md
Name: disp_bcd_formatter

Overview:
- Upstream feeder for the four-digit seven-segment driver. Produces the 16-bit display word that the driver multiplexes, one hex nibble per digit.
- Samples a 16-bit CPU-side value (PC, ALU result, register) and formats it in one of two ways: raw hex passthrough, or 4-digit packed BCD via a sequential double-dabble converter.
- The output is held stable between updates so the driver never shows a half-converted value.

Parameters:
- SAMPLE_DIV, 100000: clk cycles between automatic re-samples. Must be at least 2.
- AUTO_EN, 1: 1 enables periodic automatic sampling; 0 converts only on start.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous reset, active-high
- value_in  input  16  unsigned value to display
- mode  input  1  0 = hex passthrough, 1 = decimal (BCD)
- start  input  1  single-cycle request to sample and convert
- busy  output  1  high while a BCD conversion is in progress
- done  output  1  one-cycle pulse when display_data has just been updated
- overflow  output  1  last decimal request exceeded 9999
- display_data  output  16  packed digits, [15:12] most significant; feeds the segment driver

Behaviour:
- Reset, asynchronous and active-high:
  - State goes to IDLE, sample counter to 0.
  - display_data=16'h0000, done=0, busy=0, overflow=0.
  - Reset mid-conversion aborts it; no done pulse is produced.
- Sample counter:
  - Free-running, 0..SAMPLE_DIV-1, then wraps.
  - tick=1 in the cycle where count==SAMPLE_DIV-1 and AUTO_EN=1.
- Trigger = start OR tick. It is accepted only in IDLE. Triggers in SHIFT or DONE are dropped, not queued. start and tick in the same cycle cause exactly one conversion.
- On an accepted trigger in cycle T, value_in and mode are latched. Later changes to either have no effect on this conversion.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, trigger, mode=0: load result=value_in, overflow_next=0; go to DONE.
  - IDLE, trigger, mode=1, value_in>9999: result=16'hEEEE, overflow_next=1; go to DONE.
  - IDLE, trigger, mode=1, value_in<=9999:
    - Load the 16-bit shift register and clear the 16-bit BCD accumulator.
    - Set iteration counter=0.
    - Go to SHIFT.
  - SHIFT, each cycle:
    - Add 3 to every BCD nibble that is >=5.
    - Then shift {bcd, bin} left 1 and increment the counter.
    - After the 16th shift (counter==15 in that cycle), go to DONE.
  - DONE, one cycle:
    - display_data and overflow take the new values at the edge entering DONE.
    - done=1 for this cycle only.
    - Next state is IDLE.
- busy=1 exactly while the state is SHIFT.
- Latency from trigger cycle T to new display_data:
  - Hex or overflow path: visible in cycle T+1, done in T+1.
  - Decimal path: SHIFT covers T+1..T+16; display_data and done are visible in T+17.
- display_data changes only at the edge entering DONE. It holds its value at all other times, including while busy.
- In hex mode the overflow flag is cleared at the update.
- Boundary values, decimal mode: 0→16'h0000, 9999→16'h9999, 10000→16'hEEEE with overflow=1, 65535→16'hEEEE with overflow=1.
- Throughput: the next trigger can be accepted in the cycle after DONE, so one decimal update takes 18 cycles minimum.

Test Plan:
- Hex passthrough: mode=0, value_in=16'hBEEF, start pulse at T → display_data=16'hBEEF and done=1 in T+1, busy stays 0, overflow=0.
- Decimal conversion: mode=1, value_in=1234 (16'h04D2), start at T → busy=1 for T+1..T+16, display_data=16'h1234 and done=1 in T+17. Repeat with 0→16'h0000 and 9999→16'h9999.
- Overflow: mode=1, value_in=10000 → display_data=16'hEEEE and overflow=1 in T+1. A following decimal value_in=42 → display_data=16'h0042 and overflow=0.
- Input stability and dropped starts: mode=1, value_in=5678, start at T. Change value_in to 1111 at T+3 and pulse start at T+5 and at T+17 → display_data=16'h5678 with exactly one done pulse. A start at T+18 is accepted and yields 16'h1111 in T+35.
- Auto sampling with SAMPLE_DIV=8, AUTO_EN=1: constant value_in=321, mode=1 → done pulses recur and display_data=16'h0321 after each. A start coincident with a tick produces a single conversion.
- Reset mid-conversion: assert rst at T+8 of a decimal conversion → display_data=0, busy=0, no done pulse. After release, a start converts 7 to 16'h0007 normally.
